// File: rtl/dmac_multi_pkg.sv
// Shared encodings for the dmac_multi DMA engine: pacing modes, FSM states,
// bus direction and active-low enable levels.
package dmac_multi_pkg;

  typedef enum logic [1:0] {
    DMA_SINGLE = 2'b00,
    DMA_BURST  = 2'b01,
    DMA_DEMAND = 2'b10,
    DMA_RSVD   = 2'b11
  } dmode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  function automatic logic mode_accepted(input logic [1:0] mode);
    return (mode != DMA_RSVD);
  endfunction

endpackage

// File: rtl/dmac_addr_ctr.sv
// Loadable AW-bit address incrementer with hold; wraps modulo 2^AW.
// nxt_o exposes the post-increment value so the engine can issue it directly.
module dmac_addr_ctr #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          hold_i,
  input  logic          inc_i,
  output logic [AW-1:0] q_o,
  output logic [AW-1:0] nxt_o
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] q_q;
  logic [AW-1:0] q_d;

  // Next-address selection: load wins over increment
  always_comb begin
    nxt_o = hold_i ? q_q : (q_q + ONE);
    if (load_i) begin
      q_d = load_val_i;
    end else if (inc_i) begin
      q_d = nxt_o;
    end else begin
      q_d = q_q;
    end
  end

  // Address register
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dmac_multi.sv
// Single-channel DMA bus master with SINGLE/BURST/DEMAND pacing and pre-emption.
// Optional DMAC_FIXED_ADDR_EN adds sfix/dfix ports to hold src/dst addresses.
module dmac_multi
  import dmac_multi_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] odata,
  input  logic [DW-1:0] idata,
  output logic          rw_,
  output logic          breq_,
  input  logic          bgrt_,
  input  logic [AW-1:0] dsaddr,
  input  logic [AW-1:0] ddaddr,
  input  logic [CW-1:0] dcount,
  input  logic [1:0]    dmode,
  input  logic          dreq_,
`ifdef DMAC_FIXED_ADDR_EN
  input  logic          sfix,
  input  logic          dfix,
`endif
  output logic          busy,
  output logic          eop_
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q;
  dmode_e        mode_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] odata_q;
  logic          rw_q;
  logic          breq_q;
  logic          eop_q;
  logic          busy_q;
  logic          sfix_q;
  logic          dfix_q;

  logic          start_s;
  logic          sfix_s;
  logic          dfix_s;
  logic [AW-1:0] src_s;
  logic [AW-1:0] dst_s;
  logic [AW-1:0] src_nxt_s;
  logic [AW-1:0] dst_nxt_s;

`ifdef DMAC_FIXED_ADDR_EN
  assign sfix_s = sfix;
  assign dfix_s = dfix;
`else
  assign sfix_s = 1'b0;
  assign dfix_s = 1'b0;
`endif

  assign start_s = (state_q == S_IDLE) && (dreq_ == ENABLE_) && mode_accepted(dmode);

  dmac_addr_ctr #(.AW(AW)) u_src_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_s),
    .load_val_i (dsaddr),
    .hold_i     (sfix_q),
    .inc_i      (state_q == S_WRITE),
    .q_o        (src_s),
    .nxt_o      (src_nxt_s)
  );

  dmac_addr_ctr #(.AW(AW)) u_dst_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_s),
    .load_val_i (ddaddr),
    .hold_i     (dfix_q),
    .inc_i      (state_q == S_WRITE),
    .q_o        (dst_s),
    .nxt_o      (dst_nxt_s)
  );

  // Transfer FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= DMA_SINGLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      odata_q <= '0;
      rw_q    <= RW_READ;
      breq_q  <= DISABLE_;
      eop_q   <= DISABLE_;
      busy_q  <= 1'b0;
      sfix_q  <= 1'b0;
      dfix_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            cnt_q  <= dcount;
            mode_q <= dmode_e'(dmode);
            sfix_q <= sfix_s;
            dfix_q <= dfix_s;
            busy_q <= 1'b1;
            if (dcount == '0) begin
              eop_q   <= ENABLE_;
              state_q <= S_DONE;
            end else begin
              breq_q  <= ENABLE_;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bgrt_ == ENABLE_) begin
            addr_q  <= src_s;
            rw_q    <= RW_READ;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          odata_q <= idata;
          addr_q  <= dst_s;
          rw_q    <= RW_WRITE;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          rw_q  <= RW_READ;
          cnt_q <= (cnt_q == '0) ? cnt_q : (cnt_q - CNT_ONE);
          if (cnt_q <= CNT_ONE) begin
            breq_q  <= DISABLE_;
            eop_q   <= ENABLE_;
            state_q <= S_DONE;
          end else if (bgrt_ == DISABLE_) begin
            // Pre-empted: keep requesting so the word stream resumes on re-grant
            state_q <= S_REQ;
          end else if ((mode_q == DMA_SINGLE) ||
                       ((mode_q == DMA_DEMAND) && (dreq_ == DISABLE_))) begin
            breq_q  <= DISABLE_;
            state_q <= S_PAUSE;
          end else begin
            addr_q  <= src_nxt_s;
            state_q <= S_READ;
          end
        end
        S_PAUSE: begin
          if (dreq_ == ENABLE_) begin
            breq_q  <= ENABLE_;
            state_q <= S_REQ;
          end
        end
        S_DONE: begin
          eop_q   <= DISABLE_;
          breq_q  <= DISABLE_;
          rw_q    <= RW_READ;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          breq_q  <= DISABLE_;
          eop_q   <= DISABLE_;
          rw_q    <= RW_READ;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign addr  = addr_q;
  assign odata = odata_q;
  assign rw_   = rw_q;
  assign breq_ = breq_q;
  assign eop_  = eop_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dmac_multi.sv
// Directed self-checking bench for dmac_multi: cycle-exact bus traces per pacing mode,
// pre-emption, zero count, reserved mode, mid-transfer reset and address wrap.
module tb_dmac_multi;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [DW-1:0] odata;
  logic [DW-1:0] idata;
  logic          rw_;
  logic          breq_;
  logic          bgrt_;
  logic [AW-1:0] dsaddr;
  logic [AW-1:0] ddaddr;
  logic [CW-1:0] dcount;
  logic [1:0]    dmode;
  logic          dreq_;
  logic          busy;
  logic          eop_;

  int errors = 0;
  int checks = 0;
  int eop_cnt = 0;
  int breq_cnt = 0;
  int e0;
  int b0;

  dmac_multi #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .odata  (odata),
    .idata  (idata),
    .rw_    (rw_),
    .breq_  (breq_),
    .bgrt_  (bgrt_),
    .dsaddr (dsaddr),
    .ddaddr (ddaddr),
    .dcount (dcount),
    .dmode  (dmode),
    .dreq_  (dreq_),
`ifdef DMAC_FIXED_ADDR_EN
    .sfix   (1'b0),
    .dfix   (1'b0),
`endif
    .busy   (busy),
    .eop_   (eop_)
  );

  always #5 clk = ~clk;

  // Memory returns a tagged copy of the address being read
  assign idata = {16'hDA7A, addr};

  always @(negedge clk) begin
    if (eop_ == 1'b0) eop_cnt++;
    if (breq_ == 1'b0) breq_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [CW-1:0] n);
    dmode  = m;
    dsaddr = s;
    ddaddr = d;
    dcount = n;
    dreq_  = 1'b0;
    tick();
  endtask

  // One granted word: a read cycle at s then a write cycle at d
  task automatic word(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d);
    tick();
    check({tag, "_raddr"}, addr, s);
    check({tag, "_rrw"}, rw_, 1'b1);
    check({tag, "_rbreq"}, breq_, 1'b0);
    tick();
    check({tag, "_waddr"}, addr, d);
    check({tag, "_wrw"}, rw_, 1'b0);
    check({tag, "_wdata"}, odata, {16'hDA7A, s});
    check({tag, "_wbreq"}, breq_, 1'b0);
  endtask

  task automatic finish_xfer(input string tag);
    tick();
    check({tag, "_eop_lo"}, eop_, 1'b0);
    check({tag, "_done_breq"}, breq_, 1'b1);
    check({tag, "_done_busy"}, busy, 1'b1);
    check({tag, "_done_rw"}, rw_, 1'b1);
    tick();
    check({tag, "_eop_hi"}, eop_, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_eop_once"}, eop_cnt - e0, 1);
  endtask

  initial begin
    reset = 1'b1;
    bgrt_ = 1'b1;
    dreq_ = 1'b1;
    dmode = 2'b00;
    dsaddr = '0;
    ddaddr = '0;
    dcount = '0;
    tick();
    tick();
    check("rst_addr", addr, 16'h0000);
    check("rst_odata", odata, 32'h0);
    check("rst_rw", rw_, 1'b1);
    check("rst_breq", breq_, 1'b1);
    check("rst_eop", eop_, 1'b1);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // SINGLE, one word, grant arrives two cycles after the request
    e0 = eop_cnt;
    start(2'b00, 16'h0010, 16'h0020, 8'd1);
    dreq_ = 1'b1;
    check("t1_busy", busy, 1'b1);
    check("t1_breq", breq_, 1'b0);
    tick();
    tick();
    check("t1_wait_breq", breq_, 1'b0);
    check("t1_wait_rw", rw_, 1'b1);
    bgrt_ = 1'b0;
    word("t1", 16'h0010, 16'h0020);
    finish_xfer("t1");

    // BURST, four words under a held grant; source input changes are ignored
    e0 = eop_cnt;
    start(2'b01, 16'h0010, 16'h0020, 8'd4);
    dreq_ = 1'b1;
    dsaddr = 16'h0500;
    ddaddr = 16'h0600;
    dcount = 8'd9;
    for (int i = 0; i < 4; i++) word("t2", 16'h0010 + 16'(i), 16'h0020 + 16'(i));
    finish_xfer("t2");

    // BURST pre-empted after word 2, resumes at 12/22
    e0 = eop_cnt;
    start(2'b01, 16'h0010, 16'h0020, 8'd4);
    dreq_ = 1'b1;
    word("t3a", 16'h0010, 16'h0020);
    word("t3b", 16'h0011, 16'h0021);
    bgrt_ = 1'b1;
    tick();
    check("t3_pre_rw", rw_, 1'b1);
    check("t3_pre_breq", breq_, 1'b0);
    tick();
    tick();
    check("t3_hold_breq", breq_, 1'b0);
    check("t3_hold_addr", addr, 16'h0021);
    bgrt_ = 1'b0;
    word("t3c", 16'h0012, 16'h0022);
    word("t3d", 16'h0013, 16'h0023);
    finish_xfer("t3");

    // DEMAND, pacing drops after word 1 and returns
    e0 = eop_cnt;
    start(2'b10, 16'h0010, 16'h0020, 8'd3);
    word("t4a", 16'h0010, 16'h0020);
    dreq_ = 1'b1;
    tick();
    check("t4_pause_breq", breq_, 1'b1);
    check("t4_pause_busy", busy, 1'b1);
    tick();
    check("t4_pause2_breq", breq_, 1'b1);
    dreq_ = 1'b0;
    tick();
    check("t4_rereq", breq_, 1'b0);
    word("t4b", 16'h0011, 16'h0021);
    word("t4c", 16'h0012, 16'h0022);
    dreq_ = 1'b1;
    finish_xfer("t4");

    // SINGLE, two words: bus released between words until dreq_ returns
    e0 = eop_cnt;
    start(2'b00, 16'h0030, 16'h0040, 8'd2);
    dreq_ = 1'b1;
    word("t5a", 16'h0030, 16'h0040);
    tick();
    check("t5_pause_breq", breq_, 1'b1);
    tick();
    tick();
    check("t5_stay_breq", breq_, 1'b1);
    check("t5_stay_busy", busy, 1'b1);
    dreq_ = 1'b0;
    tick();
    check("t5_rereq", breq_, 1'b0);
    dreq_ = 1'b1;
    word("t5b", 16'h0031, 16'h0041);
    finish_xfer("t5");

    // Zero count: immediate eop_, bus never requested
    e0 = eop_cnt;
    b0 = breq_cnt;
    start(2'b01, 16'h0050, 16'h0060, 8'd0);
    dreq_ = 1'b1;
    check("t6_eop_lo", eop_, 1'b0);
    check("t6_busy", busy, 1'b1);
    check("t6_breq", breq_, 1'b1);
    tick();
    check("t6_eop_hi", eop_, 1'b1);
    check("t6_idle_busy", busy, 1'b0);
    check("t6_eop_once", eop_cnt - e0, 1);

    // Reserved mode: no response
    dmode = 2'b11;
    dcount = 8'd3;
    dreq_ = 1'b0;
    tick();
    tick();
    tick();
    check("t7_busy", busy, 1'b0);
    check("t7_breq", breq_, 1'b1);
    dreq_ = 1'b1;
    tick();
    check("t67_no_breq", breq_cnt - b0, 0);

    // Reset during the first WRITE of a burst
    e0 = eop_cnt;
    start(2'b01, 16'h0010, 16'h0020, 8'd4);
    dreq_ = 1'b1;
    tick();
    tick();
    check("t8_in_write", rw_, 1'b0);
    reset = 1'b1;
    tick();
    check("t8_addr", addr, 16'h0000);
    check("t8_odata", odata, 32'h0);
    check("t8_rw", rw_, 1'b1);
    check("t8_breq", breq_, 1'b1);
    check("t8_eop", eop_, 1'b1);
    check("t8_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check("t8_stay_idle", busy, 1'b0);
    check("t8_no_eop", eop_cnt - e0, 0);

    // Source address wraps from 0xFFFF to 0x0000
    e0 = eop_cnt;
    start(2'b01, 16'hFFFF, 16'h0100, 8'd2);
    dreq_ = 1'b1;
    word("t9a", 16'hFFFF, 16'h0100);
    word("t9b", 16'h0000, 16'h0101);
    finish_xfer("t9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
